// File: rtl/nbit_shift_add_multiplier.sv
// Sequential unsigned radix-2 shift-and-add multiplier.
// One partial-product step per clock through an n-bit carry-lookahead adder.
// Valid/ready handshakes are used on both the operand side and the product side.
// Latency is fixed at BIT_NUMBER cycles from the accepting edge to out_valid.

// n-bit carry-lookahead adder: generate/propagate per bit, (n+1)-bit sum incl. carry-out
module nbit_carry_lookahead_adder #(
  parameter int BIT_NUMBER = 64
) (
  input  logic [BIT_NUMBER-1:0] a,
  input  logic [BIT_NUMBER-1:0] b,
  output logic [BIT_NUMBER:0]   s
);

  logic [BIT_NUMBER-1:0] gen_s;
  logic [BIT_NUMBER-1:0] prop_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Resolve carries from generate/propagate terms and form the sum with carry-out
  always_comb begin
    logic carry_v;
    carry_v = 1'b0;
    s       = {(BIT_NUMBER+1){1'b0}};
    for (int i = 0; i < BIT_NUMBER; i++) begin
      s[i]    = prop_s[i] ^ carry_v;
      carry_v = gen_s[i] | (prop_s[i] & carry_v);
    end
    s[BIT_NUMBER] = carry_v;
  end

endmodule

module nbit_shift_add_multiplier #(
  parameter int BIT_NUMBER = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BIT_NUMBER-1:0]   num_one,
  input  logic [BIT_NUMBER-1:0]   num_two,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*BIT_NUMBER-1:0] product
);

  localparam int CW = $clog2(BIT_NUMBER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_NUMBER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q,     state_d;
  logic [BIT_NUMBER-1:0]   mcand_q,     mcand_d;
  logic [BIT_NUMBER-1:0]   acc_hi_q,    acc_hi_d;
  logic [BIT_NUMBER-1:0]   acc_lo_q,    acc_lo_d;
  logic [CW-1:0]           cnt_q,       cnt_d;
  logic [2*BIT_NUMBER-1:0] product_q,   product_d;
  logic                    in_ready_q,  in_ready_d;
  logic                    out_valid_q, out_valid_d;

  logic [BIT_NUMBER-1:0]   add_b_s;
  logic [BIT_NUMBER:0]     sum_s;

  // Add the multiplicand only when the current multiplier bit is set
  assign add_b_s = acc_lo_q[0] ? mcand_q : {BIT_NUMBER{1'b0}};

  nbit_carry_lookahead_adder #(
    .BIT_NUMBER(BIT_NUMBER)
  ) u_adder (
    .a(acc_hi_q),
    .b(add_b_s),
    .s(sum_s)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mcand_d    = num_one;
          acc_hi_d   = {BIT_NUMBER{1'b0}};
          acc_lo_d   = num_two;
          cnt_d      = {CW{1'b0}};
          in_ready_d = 1'b0;
          state_d    = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Carry-out of the sum shifts into acc_hi's top bit, so nothing is lost
        {acc_hi_d, acc_lo_d} = {sum_s, acc_lo_q[BIT_NUMBER-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          product_d   = {sum_s, acc_lo_q[BIT_NUMBER-1:1]};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mcand_q     <= {BIT_NUMBER{1'b0}};
      acc_hi_q    <= {BIT_NUMBER{1'b0}};
      acc_lo_q    <= {BIT_NUMBER{1'b0}};
      cnt_q       <= {CW{1'b0}};
      product_q   <= {(2*BIT_NUMBER){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_nbit_shift_add_multiplier.sv
// Testbench for nbit_shift_add_multiplier: directed 8-bit cases, a 64-bit
// extreme case and a randomized 64-bit regression against a plain-arithmetic model.
module tb_nbit_shift_add_multiplier;

  localparam int NRAND = 700;

  logic         clk;
  logic         rst_n8, rst_n64;
  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]   num_one8, num_two8;
  logic [15:0]  product8;
  logic         in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0]  num_one64, num_two64;
  logic [127:0] product64;

  int n_checks = 0;
  int n_errors = 0;

  nbit_shift_add_multiplier #(.BIT_NUMBER(8)) dut8 (
    .clk(clk), .rst_n(rst_n8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .num_one(num_one8), .num_two(num_two8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8)
  );

  nbit_shift_add_multiplier #(.BIT_NUMBER(64)) dut64 (
    .clk(clk), .rst_n(rst_n64),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .num_one(num_one64), .num_two(num_two64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .product(product64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 8-bit operation with out_ready held high: checks latency, product and return to idle
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    @(negedge clk);
    check({tag, ":in_ready_before"}, in_ready8, 1'b1);
    in_valid8 = 1'b1; num_one8 = a; num_two8 = b; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; num_one8 = 8'h00; num_two8 = 8'h00;
    check({tag, ":busy"}, in_ready8, 1'b0);
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, lat, 8);
    check({tag, ":product"}, product8, exp);
    @(posedge clk); #1;
    check({tag, ":in_ready_after"}, in_ready8, 1'b1);
    check({tag, ":out_valid_after"}, out_valid8, 1'b0);
  endtask

  // One 64-bit operation with out_ready held high
  task automatic run64(input logic [63:0] a, input logic [63:0] b, input string tag);
    int lat;
    logic [127:0] exp;
    exp = {64'h0, a} * {64'h0, b};
    @(negedge clk);
    in_valid64 = 1'b1; num_one64 = a; num_two64 = b; out_ready64 = 1'b1;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    lat = 0;
    while (!out_valid64 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, lat, 64);
    check({tag, ":product"}, product64, exp);
    @(posedge clk); #1;
    check({tag, ":in_ready_after"}, in_ready64, 1'b1);
  endtask

  initial begin
    logic [127:0] exp_q[$];
    int accepted;
    int delivered;
    int lat;

    rst_n8 = 1'b0; rst_n64 = 1'b0;
    in_valid8 = 1'b0; num_one8 = 8'h00; num_two8 = 8'h00; out_ready8 = 1'b0;
    in_valid64 = 1'b0; num_one64 = 64'h0; num_two64 = 64'h0; out_ready64 = 1'b0;
    #22;
    check("reset:in_ready8", in_ready8, 1'b1);
    check("reset:out_valid8", out_valid8, 1'b0);
    check("reset:product8", product8, 16'h0000);
    check("reset:in_ready64", in_ready64, 1'b1);
    check("reset:out_valid64", out_valid64, 1'b0);
    check("reset:product64", product64, 128'h0);
    @(negedge clk);
    rst_n8 = 1'b1; rst_n64 = 1'b1;

    // Directed 8-bit cases
    run8(8'd13, 8'd11, "mul13x11");
    run8(8'd255, 8'd255, "mul255x255");
    run8(8'd0, 8'd200, "mul0x200");
    run8(8'd200, 8'd0, "mul200x0");
    run8(8'd1, 8'd255, "mul1x255");

    // Backpressure: hold DONE while new operands are offered
    @(negedge clk);
    in_valid8 = 1'b1; num_one8 = 8'd9; num_two8 = 8'd10; out_ready8 = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk); #1;
      num_one8 = 8'($urandom); num_two8 = 8'($urandom);
      lat++;
    end
    check("bp:latency", lat, 8);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid8 = ~in_valid8;
      num_one8 = 8'($urandom); num_two8 = 8'($urandom);
      check("bp:product", product8, 16'd90);
      check("bp:out_valid", out_valid8, 1'b1);
      check("bp:in_ready", in_ready8, 1'b0);
    end
    @(negedge clk);
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("bp:released_valid", out_valid8, 1'b0);
    check("bp:released_ready", in_ready8, 1'b1);
    check("bp:product_kept", product8, 16'd90);
    run8(8'd3, 8'd5, "after_bp");

    // Reset in the middle of RUN
    @(negedge clk);
    in_valid8 = 1'b1; num_one8 = 8'd200; num_two8 = 8'd100; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n8 = 1'b0;
    #1;
    check("midrst:out_valid", out_valid8, 1'b0);
    check("midrst:in_ready", in_ready8, 1'b1);
    check("midrst:product", product8, 16'h0000);
    @(negedge clk);
    rst_n8 = 1'b1;
    run8(8'd7, 8'd6, "after_rst");

    // 64-bit extreme
    run64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "mul64max");
    check("mul64max:const", product64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Randomized back-to-back regression with random sink readiness
    accepted = 0;
    delivered = 0;
    fork
      begin : driver
        for (int i = 0; i < NRAND; i++) begin
          logic [63:0] a, b;
          logic hs;
          int waitc;
          a = {$urandom, $urandom};
          b = {$urandom, $urandom};
          if (i % 50 == 0) a = 64'hFFFF_FFFF_FFFF_FFFF;
          if (i % 70 == 1) b = 64'h0;
          if (i % 90 == 2) b = 64'h1;
          num_one64 = a; num_two64 = b; in_valid64 = 1'b1;
          hs = 1'b0;
          waitc = 0;
          while (!hs && waitc < 400) begin
            @(negedge clk);
            hs = in_ready64;
            @(posedge clk);
            waitc++;
          end
          #1;
          if (hs) begin
            exp_q.push_back({64'h0, a} * {64'h0, b});
            accepted++;
          end else begin
            check("rand:accept_timeout", 1'b0, 1'b1);
          end
        end
        in_valid64 = 1'b0;
      end
      begin : monitor
        int cyc;
        cyc = 0;
        while (delivered < NRAND && cyc < NRAND * 150) begin
          @(negedge clk);
          cyc++;
          out_ready64 = 1'($urandom);
          if (out_valid64 && out_ready64) begin
            if (exp_q.size() == 0) begin
              check("rand:unexpected_output", 1'b1, 1'b0);
            end else begin
              check("rand:product", product64, exp_q.pop_front());
            end
            delivered++;
          end
        end
        if (delivered < NRAND) check("rand:output_timeout", delivered, NRAND);
      end
    join
    check("rand:accept_count", accepted, NRAND);
    check("rand:deliver_count", delivered, accepted);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
